game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_if.sv | 30 +++
 rtl/game_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// game_ctrl_if -- bundle between game_ctrl and the rest of the game:
// per-frame/per-tick strobes and gameplay indications in, state and
// display selects out. The controller uses the slave view.
interface game_ctrl_if;
   logic       tick;
   logic       frame_start;
   logic       enter;
   logic [3:0] health;
   logic       ep_boom;
   logic       boss_boom;
   logic [1:0] state;
   logic       play_en;
   logic       end_en;
   logic       boss_en;
   logic       game_rst;
   logic       enemy_spawn;
   logic [7:0] score;
   logic       win;
   logic       paused;

   modport master (
      output tick, frame_start, enter, health, ep_boom, boss_boom,
      input  state, play_en, end_en, boss_en, game_rst, enemy_spawn, score, win, paused
   );

   modport slave (
      input  tick, frame_start, enter, health, ep_boom, boss_boom,
      output state, play_en, end_en, boss_en, game_rst, enemy_spawn, score, win, paused
   );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl -- top-level game sequencer: IDLE -> PLAY -> BOSS -> OVER.
// Counts kills and score, times enemy respawn and the end-screen hold,
// and drives frame-aligned display selects.
// Optional feature: define GAME_CTRL_PAUSE_EN to let enter toggle a pause
// during PLAY/BOSS; without it paused is tied to 0.
module game_ctrl #(
   parameter int KILLS_TO_BOSS  = 8,
   parameter int RESPAWN_TICKS  = 100,
   parameter int END_HOLD_TICKS = 300
) (
   input logic        clk,
   input logic        rst,
   game_ctrl_if.slave bus
);
   localparam int KW = $clog2(KILLS_TO_BOSS + 1);
   localparam int RW = $clog2(RESPAWN_TICKS + 1);
   localparam int HW = $clog2(END_HOLD_TICKS + 1);
   localparam logic [KW-1:0] KILL_LAST    = KW'(KILLS_TO_BOSS - 1);
   localparam logic [RW-1:0] RESPAWN_LOAD = RW'(RESPAWN_TICKS);
   localparam logic [HW-1:0] HOLD_MAX     = HW'(END_HOLD_TICKS);

   typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, BOSS = 2'b10, OVER = 2'b11} state_t;

   state_t        state_q, state_d;
   logic          enter_q, ep_q, boss_q;
   logic          enter_rise, ep_rise, boss_rise;
   logic          active, tick_ev, ep_ev, boss_ev, health_zero, score_inc;
   logic          start_game, win_d, win_q, paused_q;
   logic [KW-1:0] kill_q;
   logic [RW-1:0] resp_q;
   logic          resp_armed;
   logic [HW-1:0] hold_q;
   logic [7:0]    score_q;
   logic          game_rst_q, spawn_q, play_en_q, end_en_q, boss_en_q;

   // Edges are current level against last cycle's level; history resets to 1
   // so an input already held high at reset is not seen as an edge.
   assign enter_rise  = bus.enter & ~enter_q;
   assign ep_rise     = bus.ep_boom & ~ep_q;
   assign boss_rise   = bus.boss_boom & ~boss_q;
   assign health_zero = (bus.health == 4'd0);

   // While paused only health==0 and the unpausing enter get through.
   assign tick_ev   = bus.tick & active;
   assign ep_ev     = ep_rise & active;
   assign boss_ev   = boss_rise & active;
   assign score_inc = (state_q == PLAY && ep_ev) || (state_q == BOSS && boss_ev);

`ifdef GAME_CTRL_PAUSE_EN
   assign active = ~paused_q;

   // Pause toggles on enter in PLAY/BOSS; any start or end of a game clears it.
   always_ff @(posedge clk) begin
      if (rst)
         paused_q <= 1'b0;
      else if (start_game || state_d == OVER)
         paused_q <= 1'b0;
      else if (enter_rise && (state_q == PLAY || state_q == BOSS))
         paused_q <= ~paused_q;
   end
`else
   assign active   = 1'b1;
   assign paused_q = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
      end
   end

   // Next-state logic: health==0 always beats a simultaneous kill or boss hit.
   always_comb begin
      // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
      state_d    = state_q;
      start_game = 1'b0;
      win_d      = win_q;
      case (state_q)
         IDLE: if (enter_rise) begin
            state_d    = PLAY;
            start_game = 1'b1;
            win_d      = 1'b0;
         end
         PLAY: if (health_zero) begin
            state_d = OVER;
            win_d   = 1'b0;
         end else if (ep_ev && kill_q == KILL_LAST) begin
            state_d = BOSS;
         end
         BOSS: if (health_zero) begin
            state_d = OVER;
            win_d   = 1'b0;
         end else if (boss_ev) begin
            state_d = OVER;
            win_d   = 1'b1;
         end
         OVER: if (enter_rise && hold_q == HOLD_MAX) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Edge history, score, kill count, end-screen hold counter, restart pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         enter_q    <= 1'b1;
         ep_q       <= 1'b1;
         boss_q     <= 1'b1;
         score_q    <= 8'd0;
         kill_q     <= '0;
         hold_q     <= '0;
         game_rst_q <= 1'b0;
      end else begin
         enter_q    <= bus.enter;
         ep_q       <= bus.ep_boom;
         boss_q     <= bus.boss_boom;
         game_rst_q <= start_game;
         if (start_game) begin
            score_q <= 8'd0;
            kill_q  <= '0;
         end else begin
            if (score_inc && score_q != 8'hFF) score_q <= score_q + 8'd1;
            if (state_q == PLAY && ep_ev) kill_q <= kill_q + KW'(1);
         end
         if (state_q != OVER)
            hold_q <= '0;
         else if (tick_ev && hold_q != HOLD_MAX)
            hold_q <= hold_q + HW'(1);
      end
   end

   // Respawn timer: a kill (re)loads it, ticks count it down, and the spawn
   // pulse follows one clk after it empties. Leaving PLAY drops it silently.
   always_ff @(posedge clk) begin
      if (rst || state_q != PLAY || state_d != PLAY) begin
         resp_q     <= '0;
         resp_armed <= 1'b0;
         spawn_q    <= 1'b0;
      end else if (ep_ev) begin
         resp_q     <= RESPAWN_LOAD;
         resp_armed <= 1'b1;
         spawn_q    <= 1'b0;
      end else if (resp_armed && resp_q == '0 && active) begin
         resp_armed <= 1'b0;
         spawn_q    <= 1'b1;
      end else begin
         spawn_q <= 1'b0;
         if (tick_ev && resp_q != '0) resp_q <= resp_q - RW'(1);
      end
   end

   // Display selects change only at frame start so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         play_en_q <= 1'b0;
         end_en_q  <= 1'b0;
         boss_en_q <= 1'b0;
      end else if (bus.frame_start) begin
         play_en_q <= (state_q == PLAY) || (state_q == BOSS);
         end_en_q  <= (state_q == OVER);
         boss_en_q <= (state_q == BOSS);
      end
   end

   assign bus.state       = state_q;
   assign bus.play_en     = play_en_q;
   assign bus.end_en      = end_en_q;
   assign bus.boss_en     = boss_en_q;
   assign bus.game_rst    = game_rst_q;
   assign bus.enemy_spawn = spawn_q;
   assign bus.score       = score_q;
   assign bus.win         = win_q;
   assign bus.paused      = paused_q;
endmodule
